// File: rtl/tcdm_arb_pkg.sv
// ---------------------------------------------------------------------------
// tcdm_arb_pkg
// Shared types and helpers for the TCDM bridge arbiter.
//   - ADDR_W / DATA_W / BE_W : fixed TCDM bus widths (32-bit address and data)
//   - tcdm_req_t             : one requester's request payload
//   - idx_width()            : index width for N items, never below 1 bit
// ---------------------------------------------------------------------------
package tcdm_arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  typedef struct packed {
    logic [ADDR_W-1:0] add;
    logic              wen;   // 1 = read, 0 = write
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } tcdm_req_t;

  // A single-entry index still needs one bit to stay a legal vector.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tcdm_arb_id_fifo.sv
// ---------------------------------------------------------------------------
// tcdm_arb_id_fifo
// Circular FIFO holding the requester index of every accepted transaction,
// oldest first, so in-order responses can be routed back.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   push_i         enqueue push_data_i (ignored when full)
//   push_data_i    requester index to enqueue
//   pop_i          dequeue the head entry (ignored when empty)
//   full_o         count == DEPTH
//   empty_o        count == 0
//   head_o         oldest entry (valid only when !empty_o)
//   count_o        number of stored entries
// ---------------------------------------------------------------------------
module tcdm_arb_id_fifo
  import tcdm_arb_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned WIDTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = idx_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_en, pop_en;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  assign push_en = push_i & ~full_o;
  assign pop_en  = pop_i & ~empty_o;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    if (push_en) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop_en) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end

    unique case ({push_en, pop_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array has no reset; count_q alone decides which entries are valid.
  always_ff @(posedge clk_i) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/tcdm_bridge_arbiter.sv
// ---------------------------------------------------------------------------
// tcdm_bridge_arbiter
// Shares one TCDM->AXI bridge port among NB_REQ TCDM requesters.
// Round-robin request arbitration with a zero-latency grant path; responses
// come back in issue order and are routed through an outstanding-ID FIFO.
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   slv_req_i/add/wen/wdata/be  per-requester request and payload
//   slv_gnt_o                per-requester grant (one-hot or zero)
//   slv_r_valid_o            per-requester response valid (one-hot or zero)
//   slv_r_rdata_o/opc_o      response data/error, broadcast to all
//   mst_req_o/add/wen/wdata/be  request and winner's payload to the bridge
//   mst_gnt_i                bridge grant (combinational)
//   mst_r_valid_i/rdata/opc  bridge response
//   outstanding_o            accepted-but-unanswered transaction count
//   err_unexp_rsp_o          1-cycle pulse after a response with nothing outstanding
// ---------------------------------------------------------------------------
module tcdm_bridge_arbiter
  import tcdm_arb_pkg::*;
#(
  parameter  int unsigned NB_REQ          = 4,
  parameter  int unsigned MAX_OUTSTANDING = 4,
  parameter  int unsigned ADDR_WIDTH      = ADDR_W,
  parameter  int unsigned DATA_WIDTH      = DATA_W,
  localparam int unsigned BE_WIDTH        = DATA_WIDTH / 8,
  localparam int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  // requester side
  input  logic [NB_REQ-1:0]                  slv_req_i,
  input  logic [NB_REQ-1:0][ADDR_WIDTH-1:0]  slv_add_i,
  input  logic [NB_REQ-1:0]                  slv_wen_i,
  input  logic [NB_REQ-1:0][DATA_WIDTH-1:0]  slv_wdata_i,
  input  logic [NB_REQ-1:0][BE_WIDTH-1:0]    slv_be_i,
  output logic [NB_REQ-1:0]                  slv_gnt_o,
  output logic [NB_REQ-1:0]                  slv_r_valid_o,
  output logic [DATA_WIDTH-1:0]              slv_r_rdata_o,
  output logic                               slv_r_opc_o,
  // bridge side
  output logic                               mst_req_o,
  output logic [ADDR_WIDTH-1:0]              mst_add_o,
  output logic                               mst_wen_o,
  output logic [DATA_WIDTH-1:0]              mst_wdata_o,
  output logic [BE_WIDTH-1:0]                mst_be_o,
  input  logic                               mst_gnt_i,
  input  logic                               mst_r_valid_i,
  input  logic [DATA_WIDTH-1:0]              mst_r_rdata_i,
  input  logic                               mst_r_opc_i,
  // status
  output logic [CNT_W-1:0]                   outstanding_o,
  output logic                               err_unexp_rsp_o
);

  localparam int unsigned IDX_W = idx_width(NB_REQ);

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] fifo_head;
  logic             fifo_full, fifo_empty;
  logic             accept, rsp_hit;
  logic             err_unexp_q, err_unexp_d;
  tcdm_req_t        win_req;

  // Winner: first requester at or after the pointer, wrapping modulo NB_REQ.
  always_comb begin
    logic             found;
    logic [IDX_W-1:0] cand;
    found  = 1'b0;
    cand   = '0;
    winner = rr_ptr_q;
    for (int unsigned i = 0; i < NB_REQ; i++) begin
      cand = IDX_W'((32'(rr_ptr_q) + i) % NB_REQ);
      if (!found && slv_req_i[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // Full blocks the request outright; a same-cycle pop does not reopen it,
  // which keeps r_valid off the combinational request path.
  assign mst_req_o = (|slv_req_i) & ~fifo_full;
  assign accept    = mst_req_o & mst_gnt_i;

  always_comb begin
    slv_gnt_o = '0;
    if (accept) begin
      slv_gnt_o[winner] = 1'b1;
    end
  end

  // The bridge samples the payload only on accept, so switching winners
  // between cycles before a grant is harmless.
  assign win_req = '{
    add:   slv_add_i[winner],
    wen:   slv_wen_i[winner],
    wdata: slv_wdata_i[winner],
    be:    slv_be_i[winner]
  };
  assign mst_add_o   = win_req.add;
  assign mst_wen_o   = win_req.wen;
  assign mst_wdata_o = win_req.wdata;
  assign mst_be_o    = win_req.be;

  // Responses return in issue order, so the FIFO head owns the current one.
  // With an empty FIFO a same-cycle accept cannot be the response's source.
  assign rsp_hit = mst_r_valid_i & ~fifo_empty;

  always_comb begin
    slv_r_valid_o = '0;
    if (rsp_hit) begin
      slv_r_valid_o[fifo_head] = 1'b1;
    end
  end

  assign slv_r_rdata_o = mst_r_rdata_i;
  assign slv_r_opc_o   = mst_r_opc_i;

  assign err_unexp_d     = mst_r_valid_i & fifo_empty;
  assign err_unexp_rsp_o = err_unexp_q;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = (winner == IDX_W'(NB_REQ - 1)) ? '0 : winner + IDX_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q    <= '0;
      err_unexp_q <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      err_unexp_q <= err_unexp_d;
    end
  end

  tcdm_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (IDX_W)
  ) u_id_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (accept),
    .push_data_i (winner),
    .pop_i       (rsp_hit),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (fifo_head),
    .count_o     (outstanding_o)
  );

endmodule

// File: tb/tb_tcdm_bridge_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tcdm_bridge_arbiter
// Self-checking bench for tcdm_bridge_arbiter. A queue-based reference model
// tracks the round-robin priority and the in-order list of issued owners.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_tcdm_bridge_arbiter;

  localparam int NB_REQ  = 4;
  localparam int MAX_OUT = 4;
  localparam int CNT_W   = $clog2(MAX_OUT + 1);

  logic                         clk_i = 1'b0;
  logic                         rst_ni = 1'b0;
  logic [NB_REQ-1:0]            slv_req_i;
  logic [NB_REQ-1:0][31:0]      slv_add_i;
  logic [NB_REQ-1:0]            slv_wen_i;
  logic [NB_REQ-1:0][31:0]      slv_wdata_i;
  logic [NB_REQ-1:0][3:0]       slv_be_i;
  logic [NB_REQ-1:0]            slv_gnt_o;
  logic [NB_REQ-1:0]            slv_r_valid_o;
  logic [31:0]                  slv_r_rdata_o;
  logic                         slv_r_opc_o;
  logic                         mst_req_o;
  logic [31:0]                  mst_add_o;
  logic                         mst_wen_o;
  logic [31:0]                  mst_wdata_o;
  logic [3:0]                   mst_be_o;
  logic                         mst_gnt_i;
  logic                         mst_r_valid_i;
  logic [31:0]                  mst_r_rdata_i;
  logic                         mst_r_opc_i;
  logic [CNT_W-1:0]             outstanding_o;
  logic                         err_unexp_rsp_o;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_q[$];     // owners of issued transactions, oldest first
  int m_ptr;      // requester with highest priority
  bit m_err;      // expected err_unexp_rsp_o this cycle
  // Per-cycle expectations
  logic [NB_REQ-1:0] e_gnt, e_rvalid;
  logic              e_req;
  int                e_win;
  bit                e_unexp;

  tcdm_bridge_arbiter #(
    .NB_REQ          (NB_REQ),
    .MAX_OUTSTANDING (MAX_OUT),
    .ADDR_WIDTH      (32),
    .DATA_WIDTH      (32)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .slv_req_i       (slv_req_i),
    .slv_add_i       (slv_add_i),
    .slv_wen_i       (slv_wen_i),
    .slv_wdata_i     (slv_wdata_i),
    .slv_be_i        (slv_be_i),
    .slv_gnt_o       (slv_gnt_o),
    .slv_r_valid_o   (slv_r_valid_o),
    .slv_r_rdata_o   (slv_r_rdata_o),
    .slv_r_opc_o     (slv_r_opc_o),
    .mst_req_o       (mst_req_o),
    .mst_add_o       (mst_add_o),
    .mst_wen_o       (mst_wen_o),
    .mst_wdata_o     (mst_wdata_o),
    .mst_be_o        (mst_be_o),
    .mst_gnt_i       (mst_gnt_i),
    .mst_r_valid_i   (mst_r_valid_i),
    .mst_r_rdata_i   (mst_r_rdata_i),
    .mst_r_opc_i     (mst_r_opc_i),
    .outstanding_o   (outstanding_o),
    .err_unexp_rsp_o (err_unexp_rsp_o)
  );

  always #5 clk_i = ~clk_i;

  // ---------------- model ----------------
  task automatic model_reset();
    m_q.delete();
    m_ptr = 0;
    m_err = 1'b0;
  endtask

  task automatic model_eval();
    bit found;
    found = 1'b0;
    e_win = 0;
    for (int i = 0; i < NB_REQ; i++) begin
      int idx;
      idx = (m_ptr + i) % NB_REQ;
      if (!found && slv_req_i[idx]) begin
        e_win = idx;
        found = 1'b1;
      end
    end
    e_req    = found && (m_q.size() < MAX_OUT);
    e_gnt    = (e_req && mst_gnt_i) ? NB_REQ'(1 << e_win) : '0;
    e_rvalid = (mst_r_valid_i && m_q.size() > 0) ? NB_REQ'(1 << m_q[0]) : '0;
    e_unexp  = mst_r_valid_i && (m_q.size() == 0);
  endtask

  task automatic model_advance();
    if (e_rvalid != '0) void'(m_q.pop_front());
    if (e_req && mst_gnt_i) begin
      m_q.push_back(e_win);
      m_ptr = (e_win + 1) % NB_REQ;
    end
    m_err = e_unexp;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [NB_REQ-1:0] req, input logic gnt,
                       input logic rv, input logic [31:0] rdata);
    slv_req_i     = req;
    mst_gnt_i     = gnt;
    mst_r_valid_i = rv;
    mst_r_rdata_i = rdata;
    mst_r_opc_i   = 1'b0;
  endtask

  task automatic randomize_payload();
    for (int i = 0; i < NB_REQ; i++) begin
      slv_add_i[i]   = $urandom;
      slv_wdata_i[i] = $urandom;
      slv_be_i[i]    = 4'($urandom);
      slv_wen_i[i]   = 1'($urandom);
    end
  endtask

  task automatic settle();
    @(negedge clk_i);
    model_eval();
  endtask

  task automatic tick();
    model_advance();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_reset();
    drive('0, 1'b0, 1'b0, '0);
    rst_ni = 1'b0;
    model_reset();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive('0, 1'b0, 1'b0, '0);
    rst_ni = 1'b0;
    model_reset();
    #3;
    checks++; if (outstanding_o !== '0) begin errors++; $display("FAIL reset_outstanding: got %0d expected 0", outstanding_o); end
    checks++; if (err_unexp_rsp_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err_unexp_rsp_o); end
    checks++; if (slv_gnt_o !== '0) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", slv_gnt_o); end
    checks++; if (slv_r_valid_o !== '0) begin errors++; $display("FAIL reset_rvalid: got %b expected 0000", slv_r_valid_o); end
    checks++; if (mst_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", mst_req_o); end
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic test_single_requester();
    logic [31:0] rd;
    apply_reset();
    for (int rep = 0; rep < 2; rep++) begin
      slv_wen_i[2] = 1'b1;
      drive(4'b0100, 1'b1, 1'b0, '0);
      settle();
      checks++; if (slv_gnt_o !== 4'b0100) begin errors++; $display("FAIL single_gnt: got %b expected 0100", slv_gnt_o); end
      checks++; if (mst_add_o !== slv_add_i[2] || mst_wen_o !== 1'b1) begin errors++; $display("FAIL single_payload: got %h/%b expected %h/1", mst_add_o, mst_wen_o, slv_add_i[2]); end
      tick();
      for (int w = 0; w < 2; w++) begin
        drive('0, 1'b0, 1'b0, '0);
        settle();
        checks++; if (outstanding_o !== CNT_W'(1)) begin errors++; $display("FAIL single_outstanding: got %0d expected 1", outstanding_o); end
        checks++; if (slv_r_valid_o !== '0) begin errors++; $display("FAIL single_early_rvalid: got %b expected 0000", slv_r_valid_o); end
        tick();
      end
      rd = $urandom;
      drive('0, 1'b0, 1'b1, rd);
      settle();
      checks++; if (slv_r_valid_o !== 4'b0100) begin errors++; $display("FAIL single_rvalid: got %b expected 0100", slv_r_valid_o); end
      checks++; if (slv_r_rdata_o !== rd) begin errors++; $display("FAIL single_rdata: got %h expected %h", slv_r_rdata_o, rd); end
      tick();
      drive('0, 1'b0, 1'b0, '0);
      settle();
      checks++; if (outstanding_o !== '0) begin errors++; $display("FAIL single_drained: got %0d expected 0", outstanding_o); end
      tick();
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int c = 0; c < 6; c++) begin
      drive(4'b1111, 1'b1, c > 0, 32'($urandom));
      settle();
      checks++; if (slv_gnt_o !== NB_REQ'(1 << (c % 4))) begin errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", c, slv_gnt_o, NB_REQ'(1 << (c % 4))); end
      if (c > 0) begin
        checks++; if (slv_r_valid_o !== NB_REQ'(1 << ((c - 1) % 4))) begin errors++; $display("FAIL rr_rvalid[%0d]: got %b expected %b", c, slv_r_valid_o, NB_REQ'(1 << ((c - 1) % 4))); end
      end
      checks++; if (outstanding_o !== CNT_W'(c > 0 ? 1 : 0)) begin errors++; $display("FAIL rr_outstanding[%0d]: got %0d expected %0d", c, outstanding_o, (c > 0 ? 1 : 0)); end
      tick();
    end
    drive('0, 1'b0, 1'b1, '0);
    settle();
    checks++; if (slv_r_valid_o !== 4'b0010) begin errors++; $display("FAIL rr_last_rvalid: got %b expected 0010", slv_r_valid_o); end
    tick();
  endtask

  task automatic test_full();
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      drive(4'b1111, 1'b1, 1'b0, '0);
      settle();
      checks++; if (slv_gnt_o !== NB_REQ'(1 << c)) begin errors++; $display("FAIL full_fill_gnt[%0d]: got %b expected %b", c, slv_gnt_o, NB_REQ'(1 << c)); end
      tick();
    end
    drive(4'b1111, 1'b1, 1'b0, '0);
    settle();
    checks++; if (mst_req_o !== 1'b0 || slv_gnt_o !== '0) begin errors++; $display("FAIL full_blocked: got req=%b gnt=%b expected req=0 gnt=0000", mst_req_o, slv_gnt_o); end
    checks++; if (outstanding_o !== CNT_W'(4)) begin errors++; $display("FAIL full_count: got %0d expected 4", outstanding_o); end
    tick();
    drive(4'b1111, 1'b1, 1'b1, '0);
    settle();
    checks++; if (mst_req_o !== 1'b0 || slv_gnt_o !== '0) begin errors++; $display("FAIL full_same_cycle_pop: got req=%b gnt=%b expected req=0 gnt=0000", mst_req_o, slv_gnt_o); end
    checks++; if (slv_r_valid_o !== 4'b0001) begin errors++; $display("FAIL full_pop_rvalid: got %b expected 0001", slv_r_valid_o); end
    tick();
    drive(4'b1111, 1'b1, 1'b0, '0);
    settle();
    checks++; if (mst_req_o !== 1'b1 || slv_gnt_o !== 4'b0001) begin errors++; $display("FAIL full_resume: got req=%b gnt=%b expected req=1 gnt=0001", mst_req_o, slv_gnt_o); end
    checks++; if (outstanding_o !== CNT_W'(3)) begin errors++; $display("FAIL full_resume_count: got %0d expected 3", outstanding_o); end
    tick();
    for (int k = 0; k < 4; k++) begin
      drive('0, 1'b0, 1'b1, '0);
      settle();
      checks++; if (slv_r_valid_o !== NB_REQ'(1 << ((k + 1) % 4))) begin errors++; $display("FAIL full_drain[%0d]: got %b expected %b", k, slv_r_valid_o, NB_REQ'(1 << ((k + 1) % 4))); end
      tick();
    end
  endtask

  task automatic test_push_pop();
    apply_reset();
    drive(4'b0010, 1'b1, 1'b0, '0);
    settle();
    checks++; if (slv_gnt_o !== 4'b0010) begin errors++; $display("FAIL pp_gnt_a: got %b expected 0010", slv_gnt_o); end
    tick();
    drive(4'b1000, 1'b1, 1'b0, '0);
    settle();
    checks++; if (slv_gnt_o !== 4'b1000) begin errors++; $display("FAIL pp_gnt_b: got %b expected 1000", slv_gnt_o); end
    tick();
    drive(4'b0001, 1'b1, 1'b1, '0);
    settle();
    checks++; if (outstanding_o !== CNT_W'(2)) begin errors++; $display("FAIL pp_count_before: got %0d expected 2", outstanding_o); end
    checks++; if (slv_gnt_o !== 4'b0001 || slv_r_valid_o !== 4'b0010) begin errors++; $display("FAIL pp_both: got gnt=%b rvalid=%b expected gnt=0001 rvalid=0010", slv_gnt_o, slv_r_valid_o); end
    tick();
    drive('0, 1'b0, 1'b1, '0);
    settle();
    checks++; if (outstanding_o !== CNT_W'(2)) begin errors++; $display("FAIL pp_count_after: got %0d expected 2", outstanding_o); end
    checks++; if (slv_r_valid_o !== 4'b1000) begin errors++; $display("FAIL pp_rvalid_2: got %b expected 1000", slv_r_valid_o); end
    tick();
    drive('0, 1'b0, 1'b1, '0);
    settle();
    checks++; if (slv_r_valid_o !== 4'b0001) begin errors++; $display("FAIL pp_rvalid_3: got %b expected 0001", slv_r_valid_o); end
    tick();
    drive('0, 1'b0, 1'b0, '0);
    settle();
    checks++; if (outstanding_o !== '0) begin errors++; $display("FAIL pp_drained: got %0d expected 0", outstanding_o); end
    tick();
  endtask

  task automatic test_unexpected();
    apply_reset();
    drive('0, 1'b0, 1'b1, 32'hdead_beef);
    settle();
    checks++; if (slv_r_valid_o !== '0 || err_unexp_rsp_o !== 1'b0) begin errors++; $display("FAIL unexp_drop: got rvalid=%b err=%b expected 0000/0", slv_r_valid_o, err_unexp_rsp_o); end
    tick();
    drive('0, 1'b0, 1'b0, '0);
    settle();
    checks++; if (err_unexp_rsp_o !== 1'b1) begin errors++; $display("FAIL unexp_pulse: got %b expected 1", err_unexp_rsp_o); end
    tick();
    settle();
    checks++; if (err_unexp_rsp_o !== 1'b0) begin errors++; $display("FAIL unexp_pulse_end: got %b expected 0", err_unexp_rsp_o); end
    tick();
    // accept and response together with nothing outstanding: push only
    drive(4'b0100, 1'b1, 1'b1, '0);
    settle();
    checks++; if (slv_gnt_o !== 4'b0100 || slv_r_valid_o !== '0) begin errors++; $display("FAIL unexp_acc_gnt: got gnt=%b rvalid=%b expected 0100/0000", slv_gnt_o, slv_r_valid_o); end
    tick();
    drive('0, 1'b0, 1'b0, '0);
    settle();
    checks++; if (err_unexp_rsp_o !== 1'b1 || outstanding_o !== CNT_W'(1)) begin errors++; $display("FAIL unexp_acc_err: got err=%b cnt=%0d expected 1/1", err_unexp_rsp_o, outstanding_o); end
    tick();
    drive('0, 1'b0, 1'b1, '0);
    settle();
    checks++; if (slv_r_valid_o !== 4'b0100 || err_unexp_rsp_o !== 1'b0) begin errors++; $display("FAIL unexp_acc_rsp: got rvalid=%b err=%b expected 0100/0", slv_r_valid_o, err_unexp_rsp_o); end
    tick();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      drive(4'b1111, 1'b1, 1'b0, '0);
      settle();
      tick();
    end
    drive('0, 1'b0, 1'b0, '0);
    settle();
    checks++; if (outstanding_o !== CNT_W'(3)) begin errors++; $display("FAIL mid_pre_count: got %0d expected 3", outstanding_o); end
    @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    model_reset();
    #1;
    checks++; if (outstanding_o !== '0 || err_unexp_rsp_o !== 1'b0) begin errors++; $display("FAIL mid_cleared: got cnt=%0d err=%b expected 0/0", outstanding_o, err_unexp_rsp_o); end
    checks++; if (slv_gnt_o !== '0 || slv_r_valid_o !== '0 || mst_req_o !== 1'b0) begin errors++; $display("FAIL mid_outputs: got gnt=%b rvalid=%b req=%b expected zeros", slv_gnt_o, slv_r_valid_o, mst_req_o); end
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    drive('0, 1'b0, 1'b1, '0);
    settle();
    checks++; if (slv_r_valid_o !== '0) begin errors++; $display("FAIL mid_inflight_drop: got %b expected 0000", slv_r_valid_o); end
    tick();
    drive(4'b1111, 1'b1, 1'b0, '0);
    settle();
    checks++; if (err_unexp_rsp_o !== 1'b1) begin errors++; $display("FAIL mid_inflight_err: got %b expected 1", err_unexp_rsp_o); end
    checks++; if (slv_gnt_o !== 4'b0001) begin errors++; $display("FAIL mid_first_gnt: got %b expected 0001", slv_gnt_o); end
    tick();
    drive('0, 1'b0, 1'b1, '0);
    settle();
    checks++; if (slv_r_valid_o !== 4'b0001) begin errors++; $display("FAIL mid_rsp: got %b expected 0001", slv_r_valid_o); end
    tick();
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      randomize_payload();
      drive(($urandom_range(0, 3) == 0) ? '0 : NB_REQ'($urandom),
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom);
      mst_r_opc_i = 1'($urandom);
      settle();
      checks++; if (mst_req_o !== e_req) begin errors++; $display("FAIL rnd_req[%0d]: got %b expected %b", c, mst_req_o, e_req); end
      checks++; if (slv_gnt_o !== e_gnt) begin errors++; $display("FAIL rnd_gnt[%0d]: got %b expected %b", c, slv_gnt_o, e_gnt); end
      checks++; if (slv_r_valid_o !== e_rvalid) begin errors++; $display("FAIL rnd_rvalid[%0d]: got %b expected %b", c, slv_r_valid_o, e_rvalid); end
      checks++; if (outstanding_o !== CNT_W'(m_q.size())) begin errors++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", c, outstanding_o, m_q.size()); end
      checks++; if (err_unexp_rsp_o !== m_err) begin errors++; $display("FAIL rnd_err[%0d]: got %b expected %b", c, err_unexp_rsp_o, m_err); end
      checks++; if (slv_r_rdata_o !== mst_r_rdata_i || slv_r_opc_o !== mst_r_opc_i) begin errors++; $display("FAIL rnd_rsp_pass[%0d]: got %h/%b expected %h/%b", c, slv_r_rdata_o, slv_r_opc_o, mst_r_rdata_i, mst_r_opc_i); end
      if (e_req) begin
        checks++;
        if (mst_add_o !== slv_add_i[e_win] || mst_wen_o !== slv_wen_i[e_win] ||
            mst_wdata_o !== slv_wdata_i[e_win] || mst_be_o !== slv_be_i[e_win]) begin
          errors++;
          $display("FAIL rnd_payload[%0d]: got %h/%b/%h/%h expected requester %0d %h/%b/%h/%h", c,
                   mst_add_o, mst_wen_o, mst_wdata_o, mst_be_o, e_win,
                   slv_add_i[e_win], slv_wen_i[e_win], slv_wdata_i[e_win], slv_be_i[e_win]);
        end
      end
      tick();
    end
    for (int k = 0; k <= MAX_OUT; k++) begin
      drive('0, 1'b0, 1'b1, '0);
      settle();
      checks++; if (slv_r_valid_o !== e_rvalid) begin errors++; $display("FAIL rnd_drain[%0d]: got %b expected %b", k, slv_r_valid_o, e_rvalid); end
      tick();
    end
  endtask

  initial begin
    drive('0, 1'b0, 1'b0, '0);
    randomize_payload();
    model_reset();
    test_reset();
    test_single_requester();
    test_round_robin();
    test_full();
    test_push_pop();
    test_unexpected();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
